// File: rtl/gate_ctrl_pkg.sv
// gate_ctrl shared definitions
// state codes and default timing constants
package gate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int GATE_W_DEF   = 24;
  localparam int DEF_GATE_DEF = 2380952;
  localparam int HOLD_CYC_DEF = 16;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gate_ctrl_if.sv
// gate_ctrl measurement bus
// conditioner input, config and counter-chain controls
interface gate_ctrl_if #(
  parameter int GATE_W = 24
);

  logic              counter_in;
  logic              run;
  logic              cfg_load;
  logic [GATE_W-1:0] gate_len;
  logic              cnt_pulse;
  logic              cnt_clr;
  logic              cnt_en;
  logic              latch_stb;
  logic              busy;

  modport master (
    output counter_in,
    output run,
    output cfg_load,
    output gate_len,
    input  cnt_pulse,
    input  cnt_clr,
    input  cnt_en,
    input  latch_stb,
    input  busy
  );

  modport slave (
    input  counter_in,
    input  run,
    input  cfg_load,
    input  gate_len,
    output cnt_pulse,
    output cnt_clr,
    output cnt_en,
    output latch_stb,
    output busy
  );

endinterface

// File: rtl/gate_ctrl_sync_edge.sv
// 2-FF synchroniser plus rising-edge detector
// rise is high for one cycle per synchronised 0->1
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // metastability chain followed by previous-value register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/gate_ctrl.sv
// gate_ctrl: measurement-window sequencer
// clear -> gate -> latch -> hold framing for the counter chain
module gate_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter int GATE_W   = GATE_W_DEF,
  parameter int DEF_GATE = DEF_GATE_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  gate_ctrl_if.slave bus
);

  localparam int HW = cnt_w(HOLD_CYC);

  localparam logic [GATE_W-1:0] T_ONE = GATE_W'(1);
  localparam logic [GATE_W-1:0] T_DEF = GATE_W'(DEF_GATE);
  localparam logic [HW-1:0]     H_ONE = HW'(1);
  localparam logic [HW-1:0]     H_INI = HW'(HOLD_CYC);

  state_t            state;
  logic [GATE_W-1:0] shadow;
  logic [GATE_W-1:0] timer;
  logic [HW-1:0]     hold;
  logic              rise;
  logic              pulse_q;
  logic              clr_q;
  logic              en_q;
  logic              latch_q;
  logic              busy_q;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.counter_in),
    .rise  (rise)
  );

  // gate-length shadow; zero requests are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= T_DEF;
    end else if (bus.cfg_load && (bus.gate_len != '0)) begin
      shadow <= bus.gate_len;
    end
  end

  // count pulse only for edges seen while gating
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= rise & (state == ST_GATE);
    end
  end

  // window sequencer with registered Moore outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      hold    <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      clr_q   <= 1'b0;
      latch_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.run) begin
            state  <= ST_CLEAR;
            clr_q  <= 1'b1;
            timer  <= shadow;
            busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_GATE;
          en_q  <= 1'b1;
        end
        ST_GATE: begin
          if (timer == T_ONE) begin
            state   <= ST_LATCH;
            en_q    <= 1'b0;
            latch_q <= 1'b1;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        ST_LATCH: begin
          state <= ST_HOLD;
          hold  <= H_INI;
        end
        ST_HOLD: begin
          if (hold == H_ONE) begin
            if (bus.run) begin
              state <= ST_CLEAR;
              clr_q <= 1'b1;
              timer <= shadow;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            hold <= hold - H_ONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          en_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_pulse = pulse_q;
  assign bus.cnt_clr   = clr_q;
  assign bus.cnt_en    = en_q;
  assign bus.latch_stb = latch_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// gate_ctrl bench: offset-based window model
// plus directed literal checks
module tb_gate_ctrl;

  localparam int GW = 24;
  localparam int DG = 100;
  localparam int HC = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  gate_ctrl_if #(.GATE_W(GW)) bus ();

  gate_ctrl #(
    .GATE_W   (GW),
    .DEF_GATE (DG),
    .HOLD_CYC (HC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #21 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // stimulus-side input drivers
  logic          run_d = 1'b0;
  logic          load_d = 1'b0;
  logic [GW-1:0] len_d = '0;
  bit            per_mode = 1'b1;
  logic          man_val = 1'b0;
  logic          per_q = 1'b0;
  int            per_cnt = 0;

  always @(negedge clk) begin
    per_cnt = (per_cnt + 1) % 10;
    per_q = (per_cnt < 5);
  end

  assign bus.counter_in = per_mode ? per_q : man_val;
  assign bus.run        = run_d;
  assign bus.cfg_load   = load_d;
  assign bus.gate_len   = len_d;

  // model: position inside current measurement, -1 when idle
  int   pos = -1;
  int   g_cur = 0;
  int   shadow_m = DG;
  logic h0 = 0, h1 = 0, h2 = 0, h3 = 0;
  logic e_pulse = 0, e_clr = 0, e_en = 0, e_latch = 0, e_busy = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos = -1; g_cur = 0; shadow_m = DG;
      h0 = 0; h1 = 0; h2 = 0; h3 = 0;
      e_pulse = 0; e_clr = 0; e_en = 0; e_latch = 0; e_busy = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = h0; h0 = bus.counter_in;
      e_pulse = h2 & ~h3 & e_en;
      if (pos < 0) begin
        if (run_d) begin pos = 0; g_cur = shadow_m; end
      end else begin
        pos++;
        if (pos == g_cur + 2 + HC) begin
          if (run_d) begin pos = 0; g_cur = shadow_m; end
          else pos = -1;
        end
      end
      if (load_d && len_d != 0) shadow_m = int'(len_d);
      e_clr   = (pos == 0);
      e_en    = (pos >= 1) && (pos <= g_cur);
      e_latch = (pos == g_cur + 1);
      e_busy  = (pos >= 0);
    end
  end

  // per-cycle compare plus window bookkeeping
  int cyc = 0;
  int w_len = 0, w_pul = 0, n_clr = 0, last_latch = -1;
  int lens[$];
  int puls[$];
  int gaps[$];

  always @(negedge clk) begin
    chk("cnt_pulse", bus.cnt_pulse, e_pulse);
    chk("cnt_clr", bus.cnt_clr, e_clr);
    chk("cnt_en", bus.cnt_en, e_en);
    chk("latch_stb", bus.latch_stb, e_latch);
    chk("busy", bus.busy, e_busy);
    if (bus.cnt_clr) begin
      w_len = 0; w_pul = 0; n_clr++;
      if (last_latch >= 0) gaps.push_back(cyc - last_latch);
    end
    if (bus.cnt_en) w_len++;
    if (bus.cnt_pulse) w_pul++;
    if (bus.latch_stb) begin
      lens.push_back(w_len);
      puls.push_back(w_pul);
      last_latch = cyc;
    end
    cyc++;
  end

  task automatic wait_clr();
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!bus.cnt_clr && k < 400);
    chk("clr_timeout", bus.cnt_clr, 1);
  endtask

  task automatic wait_latch();
    int k = 0;
    do begin @(negedge clk); k++; end
    while (!bus.latch_stb && k < 400);
    chk("latch_timeout", bus.latch_stb, 1);
  endtask

  task automatic load(input int v);
    load_d = 1'b1; len_d = GW'(v);
    @(negedge clk);
    load_d = 1'b0;
  endtask

  int exp_len[7] = '{100, 100, 50, 100, 100, 30, 100};
  int exp_pul[7] = '{10, 10, 5, 10, 10, 3, 10};

  initial begin
    int c0;
    int p;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.cnt_en, 0);
    chk("rst_clr", bus.cnt_clr, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run_d = 1'b1;
    // w1: zero length request ignored
    wait_clr();
    repeat (40) @(negedge clk);
    load(0);
    // w2: 50 requested mid-gate, used from w3
    wait_clr();
    repeat (40) @(negedge clk);
    load(50);
    // w3: restore 100 for w4
    wait_clr();
    repeat (20) @(negedge clk);
    load(100);
    wait_clr();
    // w4 latch; load lands on the CLEAR entry of w5
    wait_latch();
    repeat (4) @(negedge clk);
    load(30);
    chk("clr_at_load", bus.cnt_clr, 1);
    // w6 is 30 long; restore 100 for w7
    wait_clr();
    repeat (10) @(negedge clk);
    load(100);
    // w7: stop at gate cycle 30
    wait_clr();
    repeat (30) @(negedge clk);
    run_d = 1'b0;
    wait_latch();
    c0 = n_clr;
    repeat (4) @(negedge clk);
    chk("stop_hold_busy", bus.busy, 1);
    @(negedge clk);
    chk("stop_idle_busy", bus.busy, 0);
    repeat (20) @(negedge clk);
    chk("stop_no_clr", n_clr, c0);
    chk("win_count", lens.size(), 7);
    for (int i = 0; i < 7 && i < lens.size(); i++) begin
      chk($sformatf("win%0d_len", i + 1), lens[i], exp_len[i]);
      chk($sformatf("win%0d_pulses", i + 1), puls[i], exp_pul[i]);
    end
    if (gaps.size() > 0) chk("latch_to_clr", gaps[0], 5);
    else chk("gap_seen", 0, 1);

    // last-gate-cycle edge counted, hold edge dropped
    per_mode = 1'b0;
    man_val = 1'b0;
    load(20);
    repeat (5) @(negedge clk);
    run_d = 1'b1;
    wait_clr();
    run_d = 1'b0;
    repeat (18) @(negedge clk);
    man_val = 1'b1;
    repeat (2) @(negedge clk);
    man_val = 1'b0;
    @(negedge clk);
    chk("edge_last_latch", bus.latch_stb, 1);
    chk("edge_last_pulse", bus.cnt_pulse, 1);
    @(negedge clk);
    man_val = 1'b1;
    p = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.cnt_pulse) p++;
    end
    chk("hold_edge_pulses", p, 0);
    man_val = 1'b0;
    per_mode = 1'b1;
    repeat (5) @(negedge clk);

    // async reset mid-gate, shadow back to default
    load(40);
    run_d = 1'b1;
    wait_clr();
    repeat (10) @(negedge clk);
    #5;
    reset_n = 1'b0;
    run_d = 1'b0;
    #1;
    chk("arst_en", bus.cnt_en, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_pulse", bus.cnt_pulse, 0);
    chk("arst_clr", bus.cnt_clr, 0);
    chk("arst_latch", bus.latch_stb, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", bus.busy, 0);
    run_d = 1'b1;
    wait_clr();
    run_d = 1'b0;
    wait_latch();
    @(negedge clk);
    if (lens.size() > 0) chk("post_rst_len", lens[$], DG);
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
